// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between a fixed-priority ALU path (A)
// and a handshaked long-latency path (B), and scoreboards registers with pending B writes.
`default_nettype none

module rf_wb_arbiter #(
  parameter int NumRegs      = 32,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int StarveLimit  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    a_wr_en_i,
  input  logic [AddressWidth-1:0] a_rd_addr_i,
  input  logic [DataWidth-1:0]    a_rd_data_i,
  input  logic                    b_valid_i,
  input  logic [AddressWidth-1:0] b_rd_addr_i,
  input  logic [DataWidth-1:0]    b_rd_data_i,
  output logic                    b_ready_o,
  input  logic                    issue_i,
  input  logic                    dec_rd_en_i,
  input  logic [AddressWidth-1:0] dec_rd_addr_i,
  input  logic [AddressWidth-1:0] rs1_addr_i,
  input  logic [AddressWidth-1:0] rs2_addr_i,
  output logic                    hazard_o,
  output logic                    stall_req_o,
  output logic                    rf_wr_en_o,
  output logic [AddressWidth-1:0] rf_rd_addr_o,
  output logic [DataWidth-1:0]    rf_rd_data_o
);

  localparam int                  CntWidth = $clog2(StarveLimit + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(StarveLimit);

  logic                    a_act;
  logic                    b_hs;
  logic                    b_take;
  logic                    wr_en_q;
  logic [AddressWidth-1:0] wr_addr_q;
  logic [DataWidth-1:0]    wr_data_q;
  logic                    src_b_q;
  logic [NumRegs-1:0]      busy;
  logic [NumRegs-1:0]      busy_next;
  logic [CntWidth-1:0]     starve_cnt;
  logic                    stall_q;

  // A write to x0 is treated as idle so it never blocks B.
  assign a_act     = a_wr_en_i && (a_rd_addr_i != '0);
  assign b_ready_o = !rst_i && !a_act;
  assign b_hs      = b_valid_i && b_ready_o;
  assign b_take    = b_hs && (b_rd_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      src_b_q   <= 1'b0;
    end else if (a_act) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= a_rd_addr_i;
      wr_data_q <= a_rd_data_i;
      src_b_q   <= 1'b0;
    end else if (b_take) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= b_rd_addr_i;
      wr_data_q <= b_rd_data_i;
      src_b_q   <= 1'b1;
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      src_b_q   <= 1'b0;
    end
  end

  // Gating with reset squashes a write that was registered just before reset arrived.
  assign rf_wr_en_o   = wr_en_q && !rst_i;
  assign rf_rd_addr_o = rst_i ? '0 : wr_addr_q;
  assign rf_rd_data_o = rst_i ? '0 : wr_data_q;

  // Set is applied after clear so a same-edge collision leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (wr_en_q && src_b_q) busy_next[wr_addr_q] = 1'b0;
    if (issue_i && (dec_rd_addr_i != '0)) busy_next[dec_rd_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy <= '0;
    else       busy <= busy_next;
  end

  assign hazard_o = !rst_i && (busy[rs1_addr_i] || busy[rs2_addr_i] ||
                               (dec_rd_en_i && busy[dec_rd_addr_i]));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (b_hs || !b_valid_i)      starve_cnt <= '0;
      else if (starve_cnt != CntMax) starve_cnt <= starve_cnt + 1'b1;

      if (b_hs)                      stall_q <= 1'b0;
      else if (starve_cnt == CntMax) stall_q <= 1'b1;
    end
  end

  assign stall_req_o = stall_q && !rst_i;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by constrained-random traffic,
// all cycles checked against a rule-level reference model.
`default_nettype none

module tb_rf_wb_arbiter;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_wr_en = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        issue = 1'b0;
  logic        dec_en = 1'b0;
  logic [4:0]  dec_addr = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard;
  logic        stall_req;
  logic        rf_wr_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          mbusy[32];
  bit          m_wr = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_srcb = 0;
  int          m_cnt = 0;
  bit          m_stall = 0;
  bit          last_hs = 0;

  rf_wb_arbiter #(.NumRegs(32), .DataWidth(32), .AddressWidth(5), .StarveLimit(SL)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_wr_en_i(a_wr_en), .a_rd_addr_i(a_addr), .a_rd_data_i(a_data),
    .b_valid_i(b_valid), .b_rd_addr_i(b_addr), .b_rd_data_i(b_data), .b_ready_o(b_ready),
    .issue_i(issue), .dec_rd_en_i(dec_en), .dec_rd_addr_i(dec_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .hazard_o(hazard), .stall_req_o(stall_req),
    .rf_wr_en_o(rf_wr_en), .rf_rd_addr_o(rf_addr), .rf_rd_data_o(rf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_a_act();
    return a_wr_en && (a_addr != 0);
  endfunction

  function automatic bit m_hazard();
    if (rst) return 1'b0;
    return mbusy[rs1] || mbusy[rs2] || (dec_en && mbusy[dec_addr]);
  endfunction

  // Compare every output with the model mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit hs;
    @(negedge clk);
    check("m_b_ready",   {31'b0, b_ready},   {31'b0, !rst && !m_a_act()});
    check("m_hazard",    {31'b0, hazard},    {31'b0, m_hazard()});
    check("m_stall",     {31'b0, stall_req}, {31'b0, !rst && m_stall});
    check("m_rf_wr_en",  {31'b0, rf_wr_en},  {31'b0, !rst && m_wr});
    check("m_rf_addr",   {27'b0, rf_addr},   rst ? 32'h0 : {27'b0, m_addr});
    check("m_rf_data",   rf_data,            rst ? 32'h0 : m_data);
    hs = b_valid && !rst && !m_a_act();
    last_hs = hs;
    if (rst) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_wr = 0; m_addr = '0; m_data = '0; m_srcb = 0; m_cnt = 0; m_stall = 0;
    end else begin
      if (m_wr && m_srcb) mbusy[m_addr] = 1'b0;
      if (issue && dec_addr != 0) mbusy[dec_addr] = 1'b1;
      if (hs) m_stall = 0;
      else if (m_cnt == SL) m_stall = 1;
      if (hs || !b_valid) m_cnt = 0;
      else if (m_cnt < SL) m_cnt++;
      if (m_a_act()) begin
        m_wr = 1; m_addr = a_addr; m_data = a_data; m_srcb = 0;
      end else if (hs && b_addr != 0) begin
        m_wr = 1; m_addr = b_addr; m_data = b_data; m_srcb = 1;
      end else begin
        m_wr = 0; m_addr = '0; m_data = '0; m_srcb = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with A requesting a write.
    rst = 1'b1; a_wr_en = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    tick();
    check("rst_wr_en", {31'b0, rf_wr_en}, 32'd0);
    check("rst_ready", {31'b0, b_ready}, 32'd0);
    tick();
    rst = 1'b0; a_wr_en = 1'b0;
    #1;
    check("post_rst_wr_en", {31'b0, rf_wr_en}, 32'd0);
    check("post_rst_addr",  {27'b0, rf_addr}, 32'd0);
    check("post_rst_stall", {31'b0, stall_req}, 32'd0);
    tick();
    check("post_rst_nowrite", {31'b0, rf_wr_en}, 32'd0);

    // A alone, then A to x0.
    a_wr_en = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    check("a_wr_en", {31'b0, rf_wr_en}, 32'd1);
    check("a_addr",  {27'b0, rf_addr}, 32'd5);
    check("a_data",  rf_data, 32'hDEADBEEF);
    a_addr = 5'd0;
    #1;
    check("a_x0_ready", {31'b0, b_ready}, 32'd1);
    tick();
    check("a_x0_nowrite", {31'b0, rf_wr_en}, 32'd0);

    // Conflict: A wins, B follows one cycle later.
    a_wr_en = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h1234;
    #1;
    check("conf_ready_lo", {31'b0, b_ready}, 32'd0);
    tick();
    check("conf_a_addr", {27'b0, rf_addr}, 32'd3);
    a_wr_en = 1'b0;
    #1;
    check("conf_ready_hi", {31'b0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check("conf_b_addr", {27'b0, rf_addr}, 32'd7);
    check("conf_b_data", rf_data, 32'h1234);
    tick();

    // Scoreboard: issue x9, complete through B, release two cycles later.
    issue = 1'b1; dec_addr = 5'd9;
    tick();
    issue = 1'b0; dec_addr = 5'd0; rs1 = 5'd9;
    #1;
    check("sb_hazard_set", {31'b0, hazard}, 32'd1);
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    tick();
    b_valid = 1'b0;
    check("sb_hazard_u1", {31'b0, hazard}, 32'd1);
    tick();
    check("sb_hazard_u2", {31'b0, hazard}, 32'd0);
    issue = 1'b1; dec_addr = 5'd0; rs1 = 5'd0;
    tick();
    issue = 1'b0;
    #1;
    check("sb_x0_hazard", {31'b0, hazard}, 32'd0);

    // Set/clear collision on x4.
    issue = 1'b1; dec_addr = 5'd4;
    tick();
    issue = 1'b0; b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    tick();
    b_valid = 1'b0; issue = 1'b1; dec_addr = 5'd4;
    check("coll_b_write", {27'b0, rf_addr}, 32'd4);
    tick();
    issue = 1'b0; dec_addr = 5'd0; rs1 = 5'd4;
    #1;
    check("coll_hazard", {31'b0, hazard}, 32'd1);
    rs1 = 5'd0; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    tick();

    // Starvation: A busy, B waiting.
    a_wr_en = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h55;
    for (int k = 1; k <= SL + 1; k++) begin
      tick();
      check("starve_stall", {31'b0, stall_req}, (k == SL + 1) ? 32'd1 : 32'd0);
    end
    a_wr_en = 1'b0;
    #1;
    check("starve_ready", {31'b0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check("starve_release", {31'b0, stall_req}, 32'd0);
    check("starve_b_addr", {27'b0, rf_addr}, 32'd2);
    tick();

    // Constrained-random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (!(b_valid && !last_hs)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr  = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      rst      = ($urandom_range(0, 59) == 0);
      a_wr_en  = m_stall ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      a_addr   = 5'($urandom_range(0, 7));
      a_data   = $urandom;
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      dec_en   = 1'($urandom_range(0, 1));
      dec_addr = 5'($urandom_range(0, 7));
      issue    = !m_hazard() && ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
